// File: rtl/sine_dds_gen.sv
// sine_dds_gen: DDS sine sample source for the waveform-shaping chain.
// A prescaler paces phase-accumulator ticks. Each tick captures the top
// eight phase bits plus an offset into stage 1. Stage 2 maps that phase
// through a folded quarter-wave LUT and presents it as a valid/ready
// output. A tick only fires when stage 1 can accept it, so samples are
// never dropped: backpressure stalls phase advance instead.
module sine_dds_gen #(
    parameter int PHASE_W = 24,
    parameter int DIV_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sync_clr,
    input  logic               enable,
    input  logic [DIV_W-1:0]   rate_div,
    input  logic [PHASE_W-1:0] freq_word,
    input  logic               load,
    input  logic [7:0]         phase_offset,
    output logic [7:0]         out_data,
    output logic               out_valid,
    input  logic               out_ready
);

    // Quarter-wave table: round(127 * sin(2*pi*k/256)) for k = 0..64.
    function automatic logic [7:0] quarter_sine(input logic [6:0] k);
        logic [7:0] q;
        case (k)
            7'd0:  q = 8'd0;   7'd1:  q = 8'd3;   7'd2:  q = 8'd6;   7'd3:  q = 8'd9;
            7'd4:  q = 8'd12;  7'd5:  q = 8'd16;  7'd6:  q = 8'd19;  7'd7:  q = 8'd22;
            7'd8:  q = 8'd25;  7'd9:  q = 8'd28;  7'd10: q = 8'd31;  7'd11: q = 8'd34;
            7'd12: q = 8'd37;  7'd13: q = 8'd40;  7'd14: q = 8'd43;  7'd15: q = 8'd46;
            7'd16: q = 8'd49;  7'd17: q = 8'd51;  7'd18: q = 8'd54;  7'd19: q = 8'd57;
            7'd20: q = 8'd60;  7'd21: q = 8'd63;  7'd22: q = 8'd65;  7'd23: q = 8'd68;
            7'd24: q = 8'd71;  7'd25: q = 8'd73;  7'd26: q = 8'd76;  7'd27: q = 8'd78;
            7'd28: q = 8'd81;  7'd29: q = 8'd83;  7'd30: q = 8'd85;  7'd31: q = 8'd88;
            7'd32: q = 8'd90;  7'd33: q = 8'd92;  7'd34: q = 8'd94;  7'd35: q = 8'd96;
            7'd36: q = 8'd98;  7'd37: q = 8'd100; 7'd38: q = 8'd102; 7'd39: q = 8'd104;
            7'd40: q = 8'd106; 7'd41: q = 8'd107; 7'd42: q = 8'd109; 7'd43: q = 8'd111;
            7'd44: q = 8'd112; 7'd45: q = 8'd113; 7'd46: q = 8'd115; 7'd47: q = 8'd116;
            7'd48: q = 8'd117; 7'd49: q = 8'd118; 7'd50: q = 8'd120; 7'd51: q = 8'd121;
            7'd52: q = 8'd122; 7'd53: q = 8'd122; 7'd54: q = 8'd123; 7'd55: q = 8'd124;
            7'd56: q = 8'd125; 7'd57: q = 8'd125; 7'd58: q = 8'd126; 7'd59: q = 8'd126;
            7'd60: q = 8'd126; 7'd61: q = 8'd127; 7'd62: q = 8'd127; 7'd63: q = 8'd127;
            7'd64: q = 8'd127;
            default: q = 8'd0;
        endcase
        return q;
    endfunction

    // Full-wave lookup built from the quarter table by quadrant folding.
    // The mirror index 64-i reaches entry 64 when i is 0, so the peak and
    // trough codes 255 and 1 are exact and the output never wraps.
    function automatic logic [7:0] sine_lookup(input logic [7:0] p);
        logic [6:0] fwd;
        logic [6:0] mir;
        logic [7:0] s;
        fwd = {1'b0, p[5:0]};
        mir = 7'd64 - {1'b0, p[5:0]};
        case (p[7:6])
            2'd0:    s = 8'd128 + quarter_sine(fwd);
            2'd1:    s = 8'd128 + quarter_sine(mir);
            2'd2:    s = 8'd128 - quarter_sine(fwd);
            2'd3:    s = 8'd128 - quarter_sine(mir);
            default: s = 8'd128;
        endcase
        return s;
    endfunction

    logic [PHASE_W-1:0] acc_r;
    logic [PHASE_W-1:0] freq_r;
    logic [DIV_W-1:0]   presc_r;
    logic [DIV_W-1:0]   presc_next_s;
    logic [7:0]         s1_p_r;
    logic               s1_valid_r;
    logic [7:0]         out_data_r;
    logic               out_valid_r;
    logic               s2_adv_s;
    logic               s1_accept_s;
    logic               tick_s;

    assign s2_adv_s    = !out_valid_r || out_ready;
    assign s1_accept_s = !s1_valid_r || s2_adv_s;
    assign tick_s      = enable && (presc_r == rate_div) && s1_accept_s;

    assign out_data  = out_data_r;
    assign out_valid = out_valid_r;

    // Prescaler next value: count up to rate_div, then wait there until the tick can fire.
    always_comb begin
        presc_next_s = presc_r;
        if (!enable) begin
            presc_next_s = presc_r;
        end else if (presc_r != rate_div) begin
            presc_next_s = presc_r + DIV_W'(1);
        end else if (tick_s) begin
            presc_next_s = '0;
        end else begin
            presc_next_s = presc_r;
        end
    end

    // Prescaler register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_r <= '0;
        end else if (sync_clr) begin
            presc_r <= '0;
        end else begin
            presc_r <= presc_next_s;
        end
    end

    // Frequency word: changes only on load and survives sync_clr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            freq_r <= '0;
        end else if (sync_clr) begin
            freq_r <= freq_r;
        end else if (load) begin
            freq_r <= freq_word;
        end else begin
            freq_r <= freq_r;
        end
    end

    // Phase accumulator: advances once per tick with the current freq_r.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r <= '0;
        end else if (sync_clr) begin
            acc_r <= '0;
        end else if (tick_s) begin
            acc_r <= acc_r + freq_r;
        end else begin
            acc_r <= acc_r;
        end
    end

    // Stage 1: capture the pre-update phase (plus offset) on each tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_p_r     <= 8'd0;
            s1_valid_r <= 1'b0;
        end else if (sync_clr) begin
            s1_p_r     <= 8'd0;
            s1_valid_r <= 1'b0;
        end else if (tick_s) begin
            s1_p_r     <= acc_r[PHASE_W-1 -: 8] + phase_offset;
            s1_valid_r <= 1'b1;
        end else if (s1_valid_r && s2_adv_s) begin
            s1_p_r     <= s1_p_r;
            s1_valid_r <= 1'b0;
        end else begin
            s1_p_r     <= s1_p_r;
            s1_valid_r <= s1_valid_r;
        end
    end

    // Stage 2: LUT output register, held stable while the consumer stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_r  <= 8'd128;
            out_valid_r <= 1'b0;
        end else if (sync_clr) begin
            out_data_r  <= 8'd128;
            out_valid_r <= 1'b0;
        end else if (s1_valid_r && s2_adv_s) begin
            out_data_r  <= sine_lookup(s1_p_r);
            out_valid_r <= 1'b1;
        end else if (out_valid_r && out_ready) begin
            out_data_r  <= out_data_r;
            out_valid_r <= 1'b0;
        end else begin
            out_data_r  <= out_data_r;
            out_valid_r <= out_valid_r;
        end
    end

endmodule

// File: tb/tb_sine_dds_gen.sv
// Directed testbench for sine_dds_gen: sweep, prescaler pacing, backpressure,
// offset with zero frequency, load timing, sync_clr and asynchronous reset.
module tb_sine_dds_gen;
    localparam int PHASE_W = 24;
    localparam int DIV_W   = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic               sync_clr;
    logic               enable;
    logic [DIV_W-1:0]   rate_div;
    logic [PHASE_W-1:0] freq_word;
    logic               load;
    logic [7:0]         phase_offset;
    logic [7:0]         out_data;
    logic               out_valid;
    logic               out_ready;

    int         n_vec = 0;
    int         n_err = 0;
    int         nv;
    logic [7:0] exp_phase;

    sine_dds_gen #(.PHASE_W(PHASE_W), .DIV_W(DIV_W)) dut (
        .clk(clk), .rst(rst), .sync_clr(sync_clr), .enable(enable),
        .rate_div(rate_div), .freq_word(freq_word), .load(load),
        .phase_offset(phase_offset), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    // Reference sine: 128 + round(127*sin(2*pi*p/256)), symmetric rounding.
    function automatic logic [7:0] ref_sine(input logic [7:0] p);
        real s;
        int  q;
        s = 127.0 * $sin(2.0 * 3.14159265358979 * real'(p) / 256.0);
        if (s >= 0.0) q = $rtoi(s + 0.5);
        else          q = -$rtoi(-s + 0.5);
        return 8'(128 + q);
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Run cycles with a fixed out_ready; every displayed sample is checked
    // against the expected phase, which advances by stp on each handshake.
    task automatic stream(input int cycles, input logic rdy, input logic [7:0] stp, output int nvalid);
        nvalid = 0;
        for (int i = 0; i < cycles; i++) begin
            out_ready = rdy;
            if (out_valid && out_ready) exp_phase = exp_phase + stp;
            cyc();
            if (out_valid) begin
                nvalid++;
                check_val("sample", 32'(out_data), 32'(ref_sine(exp_phase)));
            end
        end
    endtask

    task automatic restart();
        sync_clr = 1'b1;
        cyc();
        sync_clr = 1'b0;
        check_val("clr_valid", 32'(out_valid), 32'd0);
        check_val("clr_data", 32'(out_data), 32'd128);
        exp_phase = phase_offset;
    endtask

    initial begin
        rst = 1'b1; sync_clr = 1'b0; enable = 1'b0; rate_div = 16'd0;
        freq_word = 24'd0; load = 1'b0; phase_offset = 8'd0; out_ready = 1'b1;
        exp_phase = 8'd0;
        repeat (3) cyc();
        check_val("rst_valid", 32'(out_valid), 32'd0);
        check_val("rst_data", 32'(out_data), 32'd128);
        rst = 1'b0;
        cyc();
        check_val("idle_valid", 32'(out_valid), 32'd0);

        // Load step 2^16 while disabled: no ticks may fire.
        freq_word = 24'h010000; load = 1'b1;
        cyc();
        load = 1'b0;
        check_val("dis_valid", 32'(out_valid), 32'd0);

        // Basic sweep at one sample per cycle.
        enable = 1'b1;
        cyc();
        check_val("pre_valid", 32'(out_valid), 32'd0);
        check_val("pre_data", 32'(out_data), 32'd128);
        for (int n = 0; n <= 256; n++) begin
            cyc();
            check_val("sweep_valid", 32'(out_valid), 32'd1);
            check_val("sweep_data", 32'(out_data), 32'(ref_sine(8'(n))));
            if (n == 1)   check_val("sweep_1", 32'(out_data), 32'd131);
            if (n == 64)  check_val("sweep_64", 32'(out_data), 32'd255);
            if (n == 128) check_val("sweep_128", 32'(out_data), 32'd128);
            if (n == 192) check_val("sweep_192", 32'(out_data), 32'd1);
            if (n == 256) check_val("sweep_256", 32'(out_data), 32'd128);
        end

        // Mid-stream sync_clr: restarts at phase 0 with the step retained.
        restart();
        stream(5, 1'b1, 8'd1, nv);
        check_val("clr_count", 32'(nv), 32'd4);
        check_val("clr_step", 32'(out_data), 32'd137);

        // Prescaler: rate_div=3 gives one valid cycle in four.
        rate_div = 16'd3;
        restart();
        for (int i = 1; i <= 24; i++) begin
            out_ready = 1'b1;
            if (out_valid && out_ready) exp_phase = exp_phase + 8'd1;
            cyc();
            check_val("presc_valid", 32'(out_valid), 32'((i >= 5) && (((i - 5) % 4) == 0)));
            if (out_valid) check_val("presc_data", 32'(out_data), 32'(ref_sine(exp_phase)));
        end

        // Backpressure: hold 10 cycles, then continue without skips or repeats.
        rate_div = 16'd0;
        restart();
        stream(22, 1'b1, 8'd1, nv);
        check_val("bp_pre_count", 32'(nv), 32'd21);
        stream(10, 1'b0, 8'd1, nv);
        check_val("bp_hold_valid", 32'(nv), 32'd10);
        check_val("bp_hold_data", 32'(out_data), 32'd188);
        stream(20, 1'b1, 8'd1, nv);
        check_val("bp_post_count", 32'(nv), 32'd20);
        check_val("bp_post_data", 32'(out_data), 32'd234);

        // Zero frequency with offsets 64 and 192: constant peak and trough.
        enable = 1'b0; freq_word = 24'd0; load = 1'b1;
        cyc();
        load = 1'b0; enable = 1'b1; phase_offset = 8'd64;
        restart();
        stream(6, 1'b1, 8'd0, nv);
        check_val("off64_data", 32'(out_data), 32'd255);
        phase_offset = 8'd192;
        restart();
        stream(6, 1'b1, 8'd0, nv);
        check_val("off192_data", 32'(out_data), 32'd1);

        // Load semantics: freq_word alone does nothing; the load-cycle tick uses the old step.
        phase_offset = 8'd0; freq_word = 24'h010000; load = 1'b1;
        cyc();
        load = 1'b0;
        restart();
        stream(10, 1'b1, 8'd1, nv);
        freq_word = 24'h040000;
        stream(6, 1'b1, 8'd1, nv);
        check_val("noload_data", 32'(out_data), 32'(ref_sine(8'd14)));
        load = 1'b1;
        stream(1, 1'b1, 8'd1, nv);
        load = 1'b0;
        stream(2, 1'b1, 8'd1, nv);
        stream(8, 1'b1, 8'd4, nv);
        check_val("load_count", 32'(nv), 32'd8);
        check_val("load_step", 32'(out_data), 32'd246);

        // enable=0: no new ticks, the pipeline drains.
        enable = 1'b0;
        stream(3, 1'b1, 8'd4, nv);
        check_val("drain_count", 32'(nv), 32'd1);
        check_val("drain_valid", 32'(out_valid), 32'd0);

        // Asynchronous reset mid-cycle, then freq_reg must be back to zero.
        enable = 1'b1;
        restart();
        stream(5, 1'b1, 8'd4, nv);
        check_val("pre_rst_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_val("arst_valid", 32'(out_valid), 32'd0);
        check_val("arst_data", 32'(out_data), 32'd128);
        cyc();
        cyc();
        rst = 1'b0;
        exp_phase = 8'd0;
        stream(6, 1'b1, 8'd0, nv);
        check_val("arst_count", 32'(nv), 32'd5);
        check_val("arst_freq", 32'(out_data), 32'd128);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/sine_dds_gen.md
# sine_dds_gen

Direct-digital-synthesis sample source that produces the unsigned 8-bit sine stream (0–255 code range, mid-scale 128) consumed by the downstream waveform-shaping stage, such as the triangle mapper. The block combines a programmable sample-rate prescaler, a phase accumulator, a quarter-wave sine LUT with symmetry folding, and a two-stage valid/ready output pipeline. Samples are never dropped: under backpressure, phase advance stalls.

## Interface
- PHASE_W, 24, phase accumulator width (≥ 8)
- DIV_W, 16, prescaler width
- clk  input  1  sample clock
- rst  input  1  asynchronous, active-high reset
- sync_clr  input  1  synchronous clear of phase, prescaler and pipeline
- enable  input  1  prescaler run enable
- rate_div  input  DIV_W  sample period minus 1, in clk cycles
- freq_word  input  PHASE_W  phase increment per sample; captured only on load
- load  input  1  one-cycle strobe that latches freq_word into freq_reg
- phase_offset  input  8  added to the 8-bit LUT phase and sampled live
- out_data  output  8  sine sample
- out_valid  output  1  out_data holds an unconsumed sample
- out_ready  input  1  downstream accepts the sample

## Operation
**Reset values (rst=1)**
- acc=0, freq_reg=0, presc=0, s1_valid=0
- out_valid=0, out_data=8'd128

**sync_clr**
- Has priority over all other synchronous activity.
- Clears the same registers that rst clears, except freq_reg, which is retained.

**Prescaler**
- When enable=1 and presc≠rate_div: presc increments.
- When presc==rate_div, the tick is pending.
  - The tick fires only if s1_accept=1.
  - When it fires, presc returns to 0.
  - Otherwise presc holds at rate_div.
- rate_div=0 gives one tick per cycle.
- When enable=0, presc holds and no ticks fire.
- The pipeline continues to drain while enable=0.

**Tick actions**
- s1_p ← acc[PHASE_W-1 -: 8] + phase_offset (mod 256), using the pre-update acc.
- s1_valid ← 1.
- acc ← acc + freq_reg (mod 2^PHASE_W, wraps silently).
- The first sample after reset or sync_clr is therefore phase 0 plus phase_offset.

**load**
- freq_reg ← freq_word.
- If load and a tick occur in the same cycle, the accumulation uses the old freq_reg. The new value applies from the next tick.

**LUT**
- Q[k] = round(127·sin(2πk/256)), for k=0..64 (65 entries; Q[0]=0, Q[1]=3, Q[64]=127).
- Quadrant q=s1_p[7:6], index i=s1_p[5:0]:
  - q=0: 128+Q[i]
  - q=1: 128+Q[64−i]
  - q=2: 128−Q[i]
  - q=3: 128−Q[64−i]
- Output range is 1..255. All arithmetic is 8-bit unsigned with no overflow.

**Pipeline control**
- s2_adv = !out_valid | out_ready.
- s1_accept = !s1_valid | s2_adv.
- When s1_valid & s2_adv: out_data ← LUT(s1_p), out_valid ← 1, and s1 empties unless refilled by a tick in the same cycle.
- When out_valid & out_ready & !s1_valid: out_valid ← 0.
- While out_valid=1 & out_ready=0, out_data and out_valid are held stable.

## Timing
- Latency: a tick at edge t loads s1; out_data and out_valid update at edge t+1 and are visible in cycle t+1. Tick to output is 2 register stages.
- Throughput: one sample per rate_div+1 cycles. At rate_div=0 with out_ready=1, this is 1 sample/cycle with no bubbles.
- phase_offset is sampled on the tick cycle only.
- Asserting rst mid-stream clears everything immediately and asynchronously. Deasserting rst is synchronised externally.

## Test plan
- **Basic sweep:** rst then release; enable=1, rate_div=0, load freq_word=2^16, out_ready=1.
  - out_data=128 before the first valid.
  - Valid sequence is 128, 131, …, 255 (sample 64), 128 (128), 1 (192), 128 (256), with period 256.
- **Prescaler rate:** rate_div=3 with the basic settings.
  - out_valid asserts one cycle in every 4.
  - Consecutive samples step one LUT index.
- **Backpressure:** hold out_ready=0 for 10 cycles mid-sweep.
  - out_valid stays 1 and out_data is frozen.
  - After release, samples continue with no skipped index and no duplicates.
  - acc advances at most one tick beyond the held sample.
- **Offset / zero frequency:** freq_word=0, phase_offset=64 gives constant 255. phase_offset=192 gives constant 1.
- **Load semantics:** mid-run, change freq_word to 2^18 without load; the step stays 1. Pulse load; the step becomes 4 indices from the second tick after the pulse (same-cycle tick uses the old value).
- **Clear / reset:** mid-stream sync_clr gives out_valid=0 next cycle; the next sample is 128 and the step is unchanged (freq_reg kept). Asynchronous rst mid-cycle forces out_valid=0 and out_data=128 without waiting for a clk edge.
